// File: rtl/pixel_layer_arbiter_pkg.sv
// rtl/pixel_layer_arbiter_pkg.sv - shared constants and FSM encoding for the pixel layer arbiter
// Contents: game_state codes, layer indices, default layer masks, transition FSM states.
package pixel_layer_arbiter_pkg;

    localparam logic [3:0] GS_LOGO     = 4'b0000;
    localparam logic [3:0] GS_PLAY     = 4'b0001;
    localparam logic [3:0] GS_PAUSE    = 4'b0010;
    localparam logic [3:0] GS_GAMEOVER = 4'b0011;

    localparam int LAYER_FRAME = 0;
    localparam int LAYER_FIELD = 1;
    localparam int LAYER_TEXT  = 2;
    localparam int LAYER_LOGO  = 3;

    localparam logic [3:0] DEF_LOGO_MASK = 4'b1001;
    localparam logic [3:0] DEF_PLAY_MASK = 4'b0111;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_BLANK = 2'd1,
        S_FLASH = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pixel_layer_arbiter_if.sv
// rtl/pixel_layer_arbiter_if.sv - layer colour bus from the draw_* generators to the arbiter
// Signals: lay_r/lay_g/lay_b (2 bits per layer, layer i at [2i+1:2i]), lay_dav (1 bit per layer).
// master = layer generators, slave = arbiter.
interface pixel_layer_arbiter_if #(
    parameter int NUM_LAYERS = 4
);
    logic [2*NUM_LAYERS-1:0] lay_r;
    logic [2*NUM_LAYERS-1:0] lay_g;
    logic [2*NUM_LAYERS-1:0] lay_b;
    logic [NUM_LAYERS-1:0]   lay_dav;

    modport master (output lay_r, lay_g, lay_b, lay_dav);
    modport slave  (input  lay_r, lay_g, lay_b, lay_dav);
endinterface

// File: rtl/pixel_layer_arbiter_sync_delay_line.sv
// rtl/pixel_layer_arbiter_sync_delay_line.sv - fixed-depth shift register with a reset fill value
// Ports: clk, rst (sync, active-high), din[WIDTH], dout[WIDTH] = din delayed by DEPTH cycles.
module pixel_layer_arbiter_sync_delay_line #(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= RESET_VAL;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/pixel_layer_arbiter.sv
// rtl/pixel_layer_arbiter.sv - fixed-priority VGA layer mux with screen-transition sequencing
// Ports: vga_clk, rst (sync, active-high); x/y, hsync_in/vsync_in/blank_in from the timing
// generator; game_state; lay (layer bus, valid one cycle after x/y); r/g/b, win_layer, hsync/vsync
// aligned two cycles after x/y; trans_busy while a black-out is pending or running.
module pixel_layer_arbiter
    import pixel_layer_arbiter_pkg::*;
#(
    parameter int                    NUM_LAYERS     = 4,
    parameter int                    BLANK_FRAMES   = 3,
    parameter int                    FLASH_HALF     = 16,
    parameter logic [3:0]            STATE_LOGO     = GS_LOGO,
    parameter logic [3:0]            STATE_GAMEOVER = GS_GAMEOVER,
    parameter logic [NUM_LAYERS-1:0] LOGO_MASK      = DEF_LOGO_MASK,
    parameter logic [NUM_LAYERS-1:0] PLAY_MASK      = DEF_PLAY_MASK
) (
    input  logic                        vga_clk,
    input  logic                        rst,
    input  logic [10:0]                 x,
    input  logic [9:0]                  y,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        blank_in,
    input  logic [3:0]                  game_state,
    pixel_layer_arbiter_if.slave        lay,
    output logic [1:0]                  r,
    output logic [1:0]                  g,
    output logic [1:0]                  b,
    output logic                        hsync,
    output logic                        vsync,
    output logic [1:0]                  win_layer,
    output logic                        trans_busy
);
    logic [1:0] sync_d2;
    logic       blank_d1;

    // Syncs need the full two cycles; blank only needs to meet the layer data, the
    // output register supplies its second stage.
    pixel_layer_arbiter_sync_delay_line #(.DEPTH(2), .WIDTH(2), .RESET_VAL(2'b11)) u_sync_dly (
        .clk(vga_clk), .rst(rst), .din({hsync_in, vsync_in}), .dout(sync_d2)
    );
    pixel_layer_arbiter_sync_delay_line #(.DEPTH(1), .WIDTH(1), .RESET_VAL(1'b1)) u_blank_dly (
        .clk(vga_clk), .rst(rst), .din(blank_in), .dout(blank_d1)
    );

    assign hsync = sync_d2[1];
    assign vsync = sync_d2[0];

    logic       frame_start;
    logic       change;
    logic       consume;
    arb_state_t state_q, state_n;
    logic       pending_q, pending_n;
    logic [3:0] stored_q;
    logic [3:0] blank_cnt_q, blank_cnt_n;
    logic [5:0] flash_cnt_q, flash_cnt_n;
    logic       phase_q, phase_n;

    assign frame_start = (x == 11'd0) && (y == 10'd0);
    assign change      = (game_state != stored_q);

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            pending_q   <= 1'b0;
            stored_q    <= game_state;
            blank_cnt_q <= '0;
            flash_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            state_q     <= state_n;
            pending_q   <= pending_n;
            stored_q    <= game_state;
            blank_cnt_q <= blank_cnt_n;
            flash_cnt_q <= flash_cnt_n;
            phase_q     <= phase_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        blank_cnt_n = blank_cnt_q;
        flash_cnt_n = flash_cnt_q;
        phase_n     = phase_q;
        consume     = 1'b0;
        case (state_q)
            S_RUN, S_FLASH: begin
                if (frame_start) begin
                    if (pending_q) begin
                        state_n     = S_BLANK;
                        blank_cnt_n = '0;
                        consume     = 1'b1;
                    end else if (state_q == S_FLASH) begin
                        if (flash_cnt_q == 6'(FLASH_HALF - 1)) begin
                            flash_cnt_n = '0;
                            phase_n     = ~phase_q;
                        end else begin
                            flash_cnt_n = flash_cnt_q + 6'd1;
                        end
                    end
                end
            end
            S_BLANK: begin
                if (frame_start) begin
                    if (pending_q) begin
                        blank_cnt_n = '0;
                        consume     = 1'b1;
                    end else if (blank_cnt_q == 4'(BLANK_FRAMES - 1)) begin
                        state_n     = (stored_q == STATE_GAMEOVER) ? S_FLASH : S_RUN;
                        flash_cnt_n = '0;
                        phase_n     = 1'b1;
                    end else begin
                        blank_cnt_n = blank_cnt_q + 4'd1;
                    end
                end
            end
            default: state_n = S_RUN;
        endcase
        // A change in the same cycle as a consuming frame_start re-arms rather than being lost.
        pending_n = change ? 1'b1 : (consume ? 1'b0 : pending_q);
    end

    // state_q during the layer-data cycle already reflects the frame_start of the pixel being
    // arbitrated, so the output register lands state effects on the matching pixel.
    logic [NUM_LAYERS-1:0] mask;
    logic [1:0]            r_n, g_n, b_n, win_n;

    always_comb begin
        mask = (game_state == STATE_LOGO) ? LOGO_MASK : PLAY_MASK;
        if (state_q == S_FLASH && !phase_q) mask[0] = 1'b0;
        r_n   = '0;
        g_n   = '0;
        b_n   = '0;
        win_n = '0;
        // Descending scan: the last hit written is the lowest index, i.e. highest priority.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (lay.lay_dav[i] && mask[i]) begin
                r_n   = lay.lay_r[2*i +: 2];
                g_n   = lay.lay_g[2*i +: 2];
                b_n   = lay.lay_b[2*i +: 2];
                win_n = 2'(i);
            end
        end
        if (blank_d1 || state_q == S_BLANK) begin
            r_n   = '0;
            g_n   = '0;
            b_n   = '0;
            win_n = '0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r          <= '0;
            g          <= '0;
            b          <= '0;
            win_layer  <= '0;
            trans_busy <= 1'b0;
        end else begin
            r          <= r_n;
            g          <= g_n;
            b          <= b_n;
            win_layer  <= win_n;
            trans_busy <= pending_n || (state_n == S_BLANK);
        end
    end
endmodule

// File: doc/pixel_layer_arbiter.md
Name: pixel_layer_arbiter

Overview:
Shares the single VGA RGB output between the per-element drawing layers: frames, game field, next-block/score text, and logo. Each layer presents registered r/g/b plus dav one cycle after x/y. The block picks the winner by fixed priority and masks layers per game_state. It sequences screen transitions (black-out frames on a game_state change, border flashing on game over) and realigns hsync/vsync/blank to the arbitrated pixel. It sits between the draw_* layer generators and the VGA pins.

Parameters:
NUM_LAYERS, 4, number of layer inputs; index 0 = highest priority (frame layer)
BLANK_FRAMES, 3, whole frames forced black after a game_state change (1..15)
FLASH_HALF, 16, frames per half-period of the game-over border blink (1..63)
STATE_LOGO, 4'b0000, game_state code of the logo/help screen
STATE_GAMEOVER, 4'b0011, game_state code that enables border flashing
LOGO_MASK, 4'b1001, layer enable mask in STATE_LOGO
PLAY_MASK, 4'b0111, layer enable mask in all other states

Ports:
vga_clk  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
x  in  11  current pixel column, cycle-aligned with hsync_in/vsync_in/blank_in
y  in  10  current pixel row
hsync_in  in  1  raw hsync from the timing generator, aligned with x/y
vsync_in  in  1  raw vsync, aligned with x/y
blank_in  in  1  1 = outside the visible area, aligned with x/y
game_state  in  4  current game state
lay_r  in  2*NUM_LAYERS  layer red; layer i at bits [2i+1:2i]; valid 1 cycle after x/y
lay_g  in  2*NUM_LAYERS  layer green, same packing
lay_b  in  2*NUM_LAYERS  layer blue, same packing
lay_dav  in  NUM_LAYERS  layer i drives the pixel; valid 1 cycle after x/y
r  out  2  arbitrated red
g  out  2  arbitrated green
b  out  2  arbitrated blue
hsync  out  1  hsync delayed to align with r/g/b
vsync  out  1  vsync delayed to align with r/g/b
win_layer  out  2  index of the winning layer (0 when none)
trans_busy  out  1  1 while in S_BLANK or a change is pending

Behaviour:
- Latency: x/y → r/g/b = 2 cycles. Stage 1 is the layer generators; stage 2 is the registered arbitration here. hsync/vsync/blank_in pass through a 2-deep shift register.
- Reset values: r=g=b=0, win_layer=0, trans_busy=0, hsync=vsync=1 (negative-polarity inactive). Sync pipes fill with 1; blank pipe fills with 1. State=S_RUN, counters=0, blink phase=on, pending=0, stored state=game_state.
- frame_start = (x==0 && y==0) on the input side; one pulse per frame.
- Enable mask: LOGO_MASK when game_state==STATE_LOGO, else PLAY_MASK. In S_FLASH with phase off, bit 0 is additionally cleared.
- Arbitration: the lowest index i with lay_dav[i] && mask[i] wins and its colour is registered. With no winner or blank (delayed) = 1, output is 0/0/0 and win_layer=0.
- Change detect: game_state != stored state in any cycle sets pending=1 and updates stored state. A further change while pending or in S_BLANK re-arms the same way.
- FSM states: S_RUN, S_BLANK, S_FLASH.
  - S_RUN/S_FLASH: at frame_start with pending=1 → S_BLANK, blank_cnt=0, pending=0.
  - S_BLANK: output forced 0/0/0; blank_cnt increments at each frame_start.
  - S_BLANK exit: at the frame_start where blank_cnt==BLANK_FRAMES-1 with pending=0 → S_FLASH if stored==STATE_GAMEOVER, else S_RUN. On exit, flash_cnt=0 and phase=on.
  - S_BLANK restart: frame_start with pending=1 restarts blank_cnt=0 and clears pending.
  - S_FLASH: flash_cnt increments per frame_start. At FLASH_HALF-1 it wraps to 0 and toggles phase.
- Forced black takes effect on the pixel aligned with the transition frame_start; the 2-cycle alignment is applied to the state too.
- trans_busy = pending || state==S_BLANK, registered.
- Mid-frame reset: everything returns to reset values next cycle; no partial blank.

Decomposition:
- Shared package: game_state codes (STATE_LOGO, STATE_GAMEOVER, ...), layer index constants (LAYER_FRAME=0, LAYER_FIELD=1, LAYER_TEXT=2, LAYER_LOGO=3), FSM state encoding.
- One natural sub-module: sync_delay_line (parameterised depth/width shift register with reset value) for hsync/vsync/blank and the state alignment.

Test Plan:
1. Reset, game_state=1, lay_dav=4'b0110 with layer1=(3,0,0) and layer2=(0,3,0) → two cycles later r=3, g=0, b=0, win_layer=1; hsync/vsync follow inputs delayed by exactly 2.
2. game_state=0, lay_dav=4'b1110 → layer3 (logo) wins, because layers 1 and 2 are masked; lay_dav=4'b0001 → layer0 colour.
3. Change game_state 1→2 mid-frame → trans_busy=1 immediately. From next frame_start, 3 whole frames output 0/0/0 and trans_busy=1; 4th frame shows normal pixels and trans_busy=0.
4. Change to STATE_GAMEOVER with layer0 dav → after 3 black frames, the border shows for 16 frames, is absent for 16 frames (output 0 or the next layer), then shows again.
5. Second game_state change during frame 2 of S_BLANK → blank restarts; total black = 2 + 3 frames.
6. blank_in=1 with lay_dav=4'b1111 → output 0/0/0. Assert rst mid-frame in S_BLANK → next cycle r/g/b=0, hsync=vsync=1, trans_busy=0, and it resumes in S_RUN.
